sample_rca_checker: RTL and testbench

//  Response checker for the ripple-carry adder bench; the receiving end of the stimulus driver.

---
 rtl/sample_rca_checker_if.sv | 33 +++
 rtl/sample_rca_checker.sv | 122 ++++++++++++
 tb/tb_sample_rca_checker.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sample_rca_checker_if.sv
// Vector handshake plus adder tap bundle between stimulus driver and response checker.
// The driver side owns vec_valid/operands/adder results; the checker owns vec_ready.
interface sample_rca_checker_if #(
    parameter int unsigned WIDTH = 1
);
    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output vec_valid,
        output a,
        output b,
        output carry_in,
        output sum,
        output carry_out,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  a,
        input  b,
        input  carry_in,
        input  sum,
        input  carry_out,
        output vec_ready
    );
endinterface

// File: rtl/sample_rca_checker.sv
// Response checker for the ripple-carry adder bench: accepts one vector, lets the adder
// settle, compares {carry_out,sum} against a+b+carry_in and keeps pass/fail tallies.
module sample_rca_checker #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sample_rca_checker_if.slave  bus,
    input  logic [COUNT_W-1:0]   num_vectors,
    output logic [COUNT_W-1:0]   pass_count,
    output logic [COUNT_W-1:0]   fail_count,
    output logic [COUNT_W-1:0]   first_fail_index,
    output logic                 error,
    output logic                 done
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned RES_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e             state_q;
    logic [SET_W-1:0]   settle_q;
    logic [RES_W-1:0]   exp_q;
    logic [COUNT_W-1:0] pass_q;
    logic [COUNT_W-1:0] fail_q;
    logic [COUNT_W-1:0] ffi_q;
    logic [COUNT_W-1:0] idx_q;
    logic               error_q;
    logic               done_q;
    logic               ready_q;

    logic [RES_W-1:0]   exp_d;
    logic [COUNT_W-1:0] idx_d;
    logic               match;
    logic               last_vec;

    // Full-width expected result; X/Z on the adder outputs must never compare equal.
    always_comb begin
        exp_d    = {1'b0, bus.a} + {1'b0, bus.b} + RES_W'(bus.carry_in);
        idx_d    = idx_q + COUNT_W'(1);
        match    = ({bus.carry_out, bus.sum} === exp_q);
        last_vec = (num_vectors != '0) && (idx_d == num_vectors);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            exp_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            ffi_q    <= '0;
            idx_q    <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.vec_valid && ready_q) begin
                        ready_q  <= 1'b0;
                        exp_q    <= exp_d;
                        settle_q <= SET_W'(SETTLE_CYCLES - 1);
                        state_q  <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end

                CHECK: begin
                    if (match) begin
                        if (pass_q != '1) pass_q <= pass_q + COUNT_W'(1);
                    end else begin
                        if (fail_q != '1) fail_q <= fail_q + COUNT_W'(1);
                        if (!error_q) ffi_q <= idx_q;
                        error_q <= 1'b1;
                    end
                    idx_q <= idx_d;
                    if (last_vec) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end

                DONE: begin
                    ready_q <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_ready      = ready_q;
    assign pass_count         = pass_q;
    assign fail_count         = fail_q;
    assign first_fail_index   = ffi_q;
    assign error              = error_q;
    assign done               = done_q;

endmodule

// File: tb/tb_sample_rca_checker.sv
// Directed bench for sample_rca_checker: a behavioural adder with fault knobs feeds a
// 1-bit and a 4-bit checker; tallies and handshake timing are compared to hand values.
module tb_sample_rca_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        force_co0  = 1'b0;
    logic        force_sumx = 1'b0;

    logic [15:0] nv1, nv4;
    logic [15:0] pass1, fail1, ffi1, pass4, fail4, ffi4;
    logic        err1, done1, err4, done4;

    sample_rca_checker_if #(.WIDTH(1)) bus1 ();
    sample_rca_checker_if #(.WIDTH(4)) bus4 ();

    sample_rca_checker #(.WIDTH(1), .SETTLE_CYCLES(2), .COUNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .num_vectors(nv1),
        .pass_count(pass1), .fail_count(fail1), .first_fail_index(ffi1),
        .error(err1), .done(done1)
    );

    sample_rca_checker #(.WIDTH(4), .SETTLE_CYCLES(2), .COUNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .num_vectors(nv4),
        .pass_count(pass4), .fail_count(fail4), .first_fail_index(ffi4),
        .error(err4), .done(done4)
    );

    // Behavioural adders with fault knobs on the 1-bit path.
    always_comb begin
        {bus1.carry_out, bus1.sum} = {1'b0, bus1.a} + {1'b0, bus1.b} + {1'b0, bus1.carry_in};
        if (force_co0)  bus1.carry_out = 1'b0;
        if (force_sumx) bus1.sum       = 1'bx;
    end

    always_comb begin
        {bus4.carry_out, bus4.sum} = {1'b0, bus4.a} + {1'b0, bus4.b} + {4'b0, bus4.carry_in};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send1(input logic va, input logic vb, input logic vc);
        int n = 0;
        @(negedge clk);
        bus1.a = va; bus1.b = vb; bus1.carry_in = vc; bus1.vec_valid = 1'b1;
        while (!bus1.vec_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus1.vec_ready) check("send1_timeout", 32'(0), 32'(1));
        @(posedge clk);
        @(negedge clk);
        bus1.vec_valid = 1'b0;
    endtask

    task automatic wait_idle1();
        int n = 0;
        while (!(bus1.vec_ready || done1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(bus1.vec_ready || done1)) check("idle1_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_vec1(input logic va, input logic vb, input logic vc);
        send1(va, vb, vc);
        wait_idle1();
    endtask

    task automatic run_vec4(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        int n = 0;
        @(negedge clk);
        bus4.a = va; bus4.b = vb; bus4.carry_in = vc; bus4.vec_valid = 1'b1;
        while (!bus4.vec_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus4.vec_ready) check("send4_timeout", 32'(0), 32'(1));
        @(posedge clk);
        @(negedge clk);
        bus4.vec_valid = 1'b0;
        n = 0;
        while (!(bus4.vec_ready || done4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(bus4.vec_ready || done4)) check("idle4_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus1.vec_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.carry_in = 1'b0;
        bus4.vec_valid = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0; bus4.carry_in = 1'b0;
        nv1 = 16'd8;
        nv4 = 16'd2;

        // Reset values while rst is held
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready",  32'(bus1.vec_ready), 32'(0));
        check("rst_pass",   32'(pass1), 32'(0));
        check("rst_fail",   32'(fail1), 32'(0));
        check("rst_ffi",    32'(ffi1),  32'(0));
        check("rst_error",  32'(err1),  32'(0));
        check("rst_done",   32'(done1), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(bus1.vec_ready), 32'(1));

        // Test 1: exhaustive 1-bit vectors against a correct adder
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_vec1(v[2], v[1], v[0]);
            if (i == 6) check("t1_not_done_early", 32'(done1), 32'(0));
        end
        check("t1_pass",  32'(pass1), 32'(8));
        check("t1_fail",  32'(fail1), 32'(0));
        check("t1_error", 32'(err1),  32'(0));
        check("t1_done",  32'(done1), 32'(1));
        check("t1_ready", 32'(bus1.vec_ready), 32'(0));

        // Test 2: carry_out stuck at 0
        nv1 = 16'd2;
        do_reset();
        force_co0 = 1'b1;
        run_vec1(1'b1, 1'b1, 1'b0);
        run_vec1(1'b0, 1'b0, 1'b0);
        force_co0 = 1'b0;
        check("t2_pass",  32'(pass1), 32'(1));
        check("t2_fail",  32'(fail1), 32'(1));
        check("t2_ffi",   32'(ffi1),  32'(0));
        check("t2_error", 32'(err1),  32'(1));
        check("t2_done",  32'(done1), 32'(1));

        // Test 5: X on sum for vector index 2, run-forever mode
        nv1 = 16'd0;
        do_reset();
        run_vec1(1'b0, 1'b0, 1'b0);
        run_vec1(1'b0, 1'b1, 1'b0);
        force_sumx = 1'b1;
        run_vec1(1'b1, 1'b0, 1'b0);
        force_sumx = 1'b0;
        run_vec1(1'b1, 1'b1, 1'b1);
        check("t5_pass",  32'(pass1), 32'(3));
        check("t5_fail",  32'(fail1), 32'(1));
        check("t5_ffi",   32'(ffi1),  32'(2));
        check("t5_error", 32'(err1),  32'(1));
        check("t5_done",  32'(done1), 32'(0));

        // Test 4: handshake timing with vec_valid held through the busy window
        do_reset();
        @(negedge clk);
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.carry_in = 1'b1; bus1.vec_valid = 1'b1;
        check("t4_ready_pre", 32'(bus1.vec_ready), 32'(1));
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("t4_ready_busy_%0d", k), 32'(bus1.vec_ready), 32'(0));
        end
        @(negedge clk);
        check("t4_ready_back", 32'(bus1.vec_ready), 32'(1));
        check("t4_pass_at_ready", 32'(pass1), 32'(1));
        bus1.vec_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_no_extra", 32'(pass1), 32'(1));
        check("t4_fail", 32'(fail1), 32'(0));

        // Test 6: reset during SETTLE discards the in-flight vector
        do_reset();
        run_vec1(1'b0, 1'b0, 1'b1);
        run_vec1(1'b1, 1'b0, 1'b0);
        run_vec1(1'b1, 1'b1, 1'b0);
        check("t6_pass_pre", 32'(pass1), 32'(3));
        send1(1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_pass",  32'(pass1), 32'(0));
        check("t6_rst_ready", 32'(bus1.vec_ready), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready_idle", 32'(bus1.vec_ready), 32'(1));
        run_vec1(1'b0, 1'b1, 1'b1);
        force_co0 = 1'b1;
        run_vec1(1'b1, 1'b1, 1'b0);
        force_co0 = 1'b0;
        check("t6_pass", 32'(pass1), 32'(1));
        check("t6_fail", 32'(fail1), 32'(1));
        check("t6_ffi",  32'(ffi1),  32'(1));

        // Test 3: 4-bit adder, carry out of the top bit must be kept
        do_reset();
        run_vec4(4'hF, 4'h1, 1'b1);
        check("t3_pass_first", 32'(pass4), 32'(1));
        run_vec4(4'hA, 4'h5, 1'b0);
        check("t3_pass",  32'(pass4), 32'(2));
        check("t3_fail",  32'(fail4), 32'(0));
        check("t3_error", 32'(err4),  32'(0));
        check("t3_done",  32'(done4), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
